sockit_spi_ser: RTL
===================

Name: sockit_spi_ser

Overview:
Command serializer between the XIP/command producers and the SPI shift engine.
- Accepts one command word (control + up to CDW data bits) on the command stream.
- Slices the data into SDW-bit serial beats, MSB first, and sends them to the shift engine.
- If input is enabled, gathers the returned serial beats into one right-aligned word and presents it on the command-input stream.

Parameters:
CCO, 12, command control width: [11:10] iom, [9] die, [8] doe, [7] sso, [6:0] cnt
CCI, 4, response control width: [3:2] iom, [1] sso, [0] ovf
CDW, 32, command data width
SDW, 8, serial beat data width (power of 2)
SDL, $clog2(SDW), beat bit-count width (localparam)
SCW, 6+SDL, serial control width {lst, sso, doe, die, iom[1:0], bcnt[SDL-1:0]} (localparam)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
cmo_vld  input  1  command valid
cmo_ctl  input  CCO  command control
cmo_dat  input  CDW  command data, left-aligned (MSB first)
cmo_rdy  output  1  command ready
cmi_vld  output  1  response valid
cmi_ctl  output  CCI  response control
cmi_dat  output  CDW  response data, right-aligned
cmi_rdy  input  1  response ready
sdo_vld  output  1  serial output beat valid
sdo_ctl  output  SCW  serial output beat control
sdo_dat  output  SDW  serial output beat data, left-aligned
sdo_rdy  input  1  serial output ready
sdi_vld  input  1  serial input beat valid
sdi_dat  input  SDW  serial input beat data, right-aligned
sdi_rdy  output  1  serial input ready

Behaviour:
- One clock (clk). Reset is synchronous and active-low: rst=0 at a clk edge resets the block.
- All handshakes: a transfer occurs on a clk edge with vld&rdy=1. A source holds vld and its payload stable until accepted.
- Reset: state=IDL. Counters, shift and receive registers clear to 0. Outputs after reset: cmo_rdy=1; cmi_vld=0; sdo_vld=0; sdi_rdy=0; cmi_dat=0; cmi_ctl=0.
- Bit count nbit = cnt+1.
  - If cnt>CDW-1: nbit clamps to CDW and the latched ovf flag is set.
  - Beats nbt = ceil(nbit/SDW). Last beat bits = nbit-(nbt-1)*SDW.
- FSM IDL: cmo_rdy=1. On cmo_vld, latch ctl/dat, compute nbt and ovf, clear rx, then go to SHF. Command-to-first-beat latency is 1 cycle.
- FSM SHF: sdo_vld=1.
  - sdo_dat = shift[CDW-1 -: SDW].
  - bcnt = bits in this beat minus 1; lst=1 on the last beat; sso/doe/die/iom copied from the latched command.
  - On sdo_rdy, shift left by SDW and decrement the remaining beat count.
  - On last-beat acceptance: if die=1, go to RCV; else go to IDL.
- Input collection runs in SHF and RCV when die=1.
  - sdi_rdy=1 while received beats < nbt.
  - Each accepted beat: rx = (rx<<n) | (sdi_dat & ((1<<n)-1)), where n=SDW, or the last-beat bit count for the final beat.
  - Input beats may arrive before or alongside output beats; they are counted independently.
- FSM RCV: wait for received beats = nbt, then go to RSP.
  - If the final input beat and the final output beat are accepted in the same cycle, go from SHF directly to RSP.
- FSM RSP: cmi_vld=1; cmi_dat=rx (upper CDW-nbit bits zero); cmi_ctl={iom, sso, ovf}. On cmi_rdy, go to IDL.
- die=0: sdi_rdy stays 0 and no response is produced.
- doe=0: beats are still issued (clock-only); the sdo_dat content is unspecified to the receiver.
- iom values are passed through unchecked. Reserved iom=11 is forwarded as is, and nbit that is not a multiple of the lane width is not checked.
- Reset mid-operation: the current command and partial rx are dropped and no response is produced. The shift engine must be reset in the same cycle.

Decomposition:
- Package sockit_spi_pkg:
  - iom encoding enum (00 single/3-wire, 01 dual, 10 quad)
  - cmo_ctl and cmi_ctl field offsets
  - sdo_ctl packed struct
  - FSM state enum {IDL, SHF, RCV, RSP}
- One natural sub-module, sockit_spi_ser_rx: the variable-width receive shifter plus beat counter.

Test Plan:
- Write 32b: cmo_ctl iom=00 die=0 doe=1 sso=1 cnt=31, dat=0x0B123456 -> 4 beats 0x0B,0x12,0x34,0x56, bcnt=7, lst only on the 4th; no cmi_vld; cmo_rdy back to 1 the cycle after the 4th accept.
- Read 32b: die=1 doe=0 cnt=31; sdi beats 0xDE,0xAD,0xBE,0xEF -> cmi_dat=0xDEADBEEF, cmi_ctl ovf=0.
- Partial: die=1 cnt=11 dat=0xABC00000 -> sdo 0xAB (bcnt=7), 0xC0 (bcnt=3, lst=1); sdi 0x5A,0x03 -> cmi_dat=0x000005A3.
- Clamp: cnt=0x45 -> 4 beats, cmi_ctl[0]=1.
- Backpressure: sdo_rdy=0 for 3 cycles mid-command and cmi_rdy=0 for 5 cycles -> sdo_dat/sdo_ctl and cmi_dat stable, no lost or duplicated beats. Also sdi beat accepted before first sdo accept -> correct result.
- Reset: rst=0 during the 2nd beat of a read -> next cycle cmo_rdy=1, sdo_vld=0, sdi_rdy=0; a following command completes correctly.

Source files
------------

// File: rtl/sockit_spi_ser_pkg.sv
// Shared types and field offsets for the SPI command serializer.
//   iom_t      : I/O lane mode (single/3-wire, dual, quad, reserved)
//   CCO_*/CCI_*: bit offsets inside cmo_ctl / cmi_ctl
//   sdo_hdr_t  : fixed-width upper part of sdo_ctl; the beat bit count
//                (SDL bits, depends on SDW) is appended below it
//   state_t    : serializer FSM states
package sockit_spi_pkg;

    typedef enum logic [1:0] {
        IOM_SINGLE = 2'b00,
        IOM_DUAL   = 2'b01,
        IOM_QUAD   = 2'b10,
        IOM_RSVD   = 2'b11
    } iom_t;

    // cmo_ctl layout: [11:10] iom, [9] die, [8] doe, [7] sso, [6:0] cnt
    localparam int unsigned CCO_IOM = 10;
    localparam int unsigned CCO_DIE = 9;
    localparam int unsigned CCO_DOE = 8;
    localparam int unsigned CCO_SSO = 7;
    localparam int unsigned CCO_CNT = 0;
    localparam int unsigned CNT_W   = 7;

    // cmi_ctl layout: [3:2] iom, [1] sso, [0] ovf
    localparam int unsigned CCI_IOM = 2;
    localparam int unsigned CCI_SSO = 1;
    localparam int unsigned CCI_OVF = 0;

    // sdo_ctl = {sdo_hdr_t, bcnt[SDL-1:0]}
    typedef struct packed {
        logic lst;
        logic sso;
        logic doe;
        logic die;
        iom_t iom;
    } sdo_hdr_t;

    typedef enum logic [1:0] {
        IDL,
        SHF,
        RCV,
        RSP
    } state_t;

endpackage

// File: rtl/sockit_spi_ser_if.sv
// Handshake bundle of the command serializer.
//   cmo_* : command stream in (producer -> serializer)
//   cmi_* : response stream out (serializer -> producer)
//   sdo_* : serial output beats (serializer -> shift engine)
//   sdi_* : serial input beats (shift engine -> serializer)
// Modport slave is the serializer side, master the surrounding logic.
interface sockit_spi_ser_if #(
    parameter  int unsigned CCO = 12,
    parameter  int unsigned CCI = 4,
    parameter  int unsigned CDW = 32,
    parameter  int unsigned SDW = 8,
    localparam int unsigned SDL = $clog2(SDW),
    localparam int unsigned SCW = 6 + SDL
);

    logic           cmo_vld;
    logic [CCO-1:0] cmo_ctl;
    logic [CDW-1:0] cmo_dat;
    logic           cmo_rdy;

    logic           cmi_vld;
    logic [CCI-1:0] cmi_ctl;
    logic [CDW-1:0] cmi_dat;
    logic           cmi_rdy;

    logic           sdo_vld;
    logic [SCW-1:0] sdo_ctl;
    logic [SDW-1:0] sdo_dat;
    logic           sdo_rdy;

    logic           sdi_vld;
    logic [SDW-1:0] sdi_dat;
    logic           sdi_rdy;

    modport slave (
        input  cmo_vld, cmo_ctl, cmo_dat, output cmo_rdy,
        output cmi_vld, cmi_ctl, cmi_dat, input  cmi_rdy,
        output sdo_vld, sdo_ctl, sdo_dat, input  sdo_rdy,
        input  sdi_vld, sdi_dat,          output sdi_rdy
    );

    modport master (
        output cmo_vld, cmo_ctl, cmo_dat, input  cmo_rdy,
        input  cmi_vld, cmi_ctl, cmi_dat, output cmi_rdy,
        input  sdo_vld, sdo_ctl, sdo_dat, output sdo_rdy,
        output sdi_vld, sdi_dat,          input  sdi_rdy
    );

endinterface

// File: rtl/sockit_spi_ser_rx.sv
// Receive side of the serializer: variable-width input shifter and beat counter.
//   clk, rst : clock, synchronous active-low reset
//   clr      : start of a new command, clears count and data
//   en       : collection enabled (die=1 and shifting/receiving)
//   nbt      : number of beats in the command
//   lbcnt    : bits in the final beat minus 1
//   sdi_*    : serial input beat handshake (data right-aligned)
//   rx_dat   : gathered word, right-aligned
//   done_nxt : all beats will have been received after this clock edge
module sockit_spi_ser_rx #(
    parameter  int unsigned CDW = 32,
    parameter  int unsigned SDW = 8,
    parameter  int unsigned NBW = 3,
    localparam int unsigned SDL = $clog2(SDW)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [NBW-1:0] nbt,
    input  logic [SDL-1:0] lbcnt,
    input  logic           sdi_vld,
    input  logic [SDW-1:0] sdi_dat,
    output logic           sdi_rdy,
    output logic [CDW-1:0] rx_dat,
    output logic           done_nxt
);

    logic [NBW-1:0] cnt;
    logic [CDW-1:0] rx;
    logic           last;
    logic           xfer;
    logic [SDW-1:0] mask;
    logic [SDL:0]   nsh;

    assign sdi_rdy = en && (cnt < nbt);
    assign rx_dat  = rx;

    // The final beat only contributes lbcnt+1 bits, so both the shift
    // distance and the data mask shrink for it.
    always_comb begin
        last = (cnt == nbt - NBW'(1));
        xfer = sdi_vld && sdi_rdy;
        mask = '1;
        nsh  = (SDL+1)'(SDW);
        if (last) begin
            nsh = {1'b0, lbcnt} + (SDL+1)'(1);
            for (int unsigned i = 0; i < SDW; i++) begin
                mask[i] = (SDL'(i) <= lbcnt);
            end
        end
        done_nxt = (cnt == nbt) || (last && xfer);
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
            rx  <= '0;
        end else if (xfer) begin
            cnt <= cnt + NBW'(1);
            rx  <= (rx << nsh) | CDW'(sdi_dat & mask);
        end
    end

endmodule

// File: rtl/sockit_spi_ser.sv
// Command serializer between command producers and the SPI shift engine.
// Takes one command word, slices its left-aligned data into SDW-bit beats
// (MSB first) for the shift engine, and when input is enabled gathers the
// returned beats into one right-aligned response word.
//   clk : clock
//   rst : synchronous active-low reset
//   bus : command, response, serial-out and serial-in handshakes
module sockit_spi_ser
    import sockit_spi_pkg::*;
#(
    parameter int unsigned CCO = 12,
    parameter int unsigned CCI = 4,
    parameter int unsigned CDW = 32,
    parameter int unsigned SDW = 8
) (
    input  logic             clk,
    input  logic             rst,
    sockit_spi_ser_if.slave  bus
);

    localparam int unsigned SDL = $clog2(SDW);
    localparam int unsigned NBW = $clog2(CDW / SDW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CDW - 1);

    state_t         state;
    iom_t           iom;
    logic           sso;
    logic           doe;
    logic           die;
    logic           ovf;
    logic [CDW-1:0] shift;
    logic [NBW-1:0] tx_rem;
    logic [NBW-1:0] nbt;
    logic [SDL-1:0] lbcnt;
    logic           cmo_rdy_r;
    logic           sdo_vld_r;
    logic           cmi_vld_r;

    logic [CNT_W-1:0] cmd_cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic             cmd_ovf;
    logic [NBW-1:0]   cmd_nbt;
    logic             tx_last;
    sdo_hdr_t         sdo_hdr;
    logic             rx_clr;
    logic             rx_en;
    logic             rx_done_nxt;
    logic [CDW-1:0]   rx_dat;

    // nbt = ceil((cnt_eff+1)/SDW); the final beat carries cnt_eff mod SDW + 1 bits.
    always_comb begin
        cmd_cnt = bus.cmo_ctl[CCO_CNT +: CNT_W];
        cmd_ovf = cmd_cnt > CNT_MAX;
        cnt_eff = cmd_ovf ? CNT_MAX : cmd_cnt;
        cmd_nbt = NBW'(cnt_eff >> SDL) + NBW'(1);
    end

    assign tx_last = (tx_rem == NBW'(1));
    assign rx_clr  = bus.cmo_vld && cmo_rdy_r;
    assign rx_en   = die && ((state == SHF) || (state == RCV));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDL;
            iom       <= IOM_SINGLE;
            sso       <= 1'b0;
            doe       <= 1'b0;
            die       <= 1'b0;
            ovf       <= 1'b0;
            shift     <= '0;
            tx_rem    <= '0;
            nbt       <= '0;
            lbcnt     <= '0;
            cmo_rdy_r <= 1'b1;
            sdo_vld_r <= 1'b0;
            cmi_vld_r <= 1'b0;
        end else begin
            case (state)
                IDL: begin
                    if (bus.cmo_vld) begin
                        iom       <= iom_t'(bus.cmo_ctl[CCO_IOM +: 2]);
                        die       <= bus.cmo_ctl[CCO_DIE];
                        doe       <= bus.cmo_ctl[CCO_DOE];
                        sso       <= bus.cmo_ctl[CCO_SSO];
                        ovf       <= cmd_ovf;
                        shift     <= bus.cmo_dat;
                        tx_rem    <= cmd_nbt;
                        nbt       <= cmd_nbt;
                        lbcnt     <= cnt_eff[SDL-1:0];
                        cmo_rdy_r <= 1'b0;
                        sdo_vld_r <= 1'b1;
                        state     <= SHF;
                    end
                end
                SHF: begin
                    if (bus.sdo_rdy) begin
                        shift  <= shift << SDW;
                        tx_rem <= tx_rem - NBW'(1);
                        if (tx_last) begin
                            sdo_vld_r <= 1'b0;
                            if (!die) begin
                                cmo_rdy_r <= 1'b1;
                                state     <= IDL;
                            end else if (rx_done_nxt) begin
                                // input already complete: skip RCV
                                cmi_vld_r <= 1'b1;
                                state     <= RSP;
                            end else begin
                                state <= RCV;
                            end
                        end
                    end
                end
                RCV: begin
                    if (rx_done_nxt) begin
                        cmi_vld_r <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (bus.cmi_rdy) begin
                        cmi_vld_r <= 1'b0;
                        cmo_rdy_r <= 1'b1;
                        state     <= IDL;
                    end
                end
                default: state <= IDL;
            endcase
        end
    end

    always_comb begin
        sdo_hdr     = '0;
        sdo_hdr.lst = tx_last;
        sdo_hdr.sso = sso;
        sdo_hdr.doe = doe;
        sdo_hdr.die = die;
        sdo_hdr.iom = iom;
    end

    assign bus.cmo_rdy = cmo_rdy_r;
    assign bus.sdo_vld = sdo_vld_r;
    assign bus.sdo_dat = shift[CDW-1 -: SDW];
    assign bus.sdo_ctl = {sdo_hdr, tx_last ? lbcnt : SDL'(SDW - 1)};
    assign bus.cmi_vld = cmi_vld_r;
    assign bus.cmi_ctl = {iom, sso, ovf};
    assign bus.cmi_dat = rx_dat;

    sockit_spi_ser_rx #(
        .CDW (CDW),
        .SDW (SDW),
        .NBW (NBW)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .clr      (rx_clr),
        .en       (rx_en),
        .nbt      (nbt),
        .lbcnt    (lbcnt),
        .sdi_vld  (bus.sdi_vld),
        .sdi_dat  (bus.sdi_dat),
        .sdi_rdy  (bus.sdi_rdy),
        .rx_dat   (rx_dat),
        .done_nxt (rx_done_nxt)
    );

endmodule
